// File: rtl/mdu_pkg.sv
// Shared types and defaults for the iterative multiply/divide unit.
// Op and state encodings live here so the top, the interface and the bench agree on them.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } mdu_state_e;

  function automatic logic op_is_signed(mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

  function automatic logic op_is_div(mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface mdu_if
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, in0, in1,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, in0, in1,
    output busy, done, div_by_zero, hi, lo
  );

endinterface

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate; used both to take operand magnitudes
// and to restore the sign of results.
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  assign y = neg ? ({W{1'b0}} - a) : a;

endmodule

// File: rtl/mdu.sv
// Iterative mult/multu/div/divu unit holding the architectural HI/LO registers.
//   state | meaning
//   IDLE  | waiting for start; operands and sign flags latched on start
//   RUN   | one shift-add or restoring shift-subtract step per cycle, then one settle cycle
//   FIN   | sign correction; hi/lo written and done pulsed on the exit edge
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  mdu_state_e         state, state_nxt;
  mdu_op_e            op_q, op_in;
  logic               sign0, sign1, dz;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   b, acc, q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, dbz_q;

  logic               in_signed, neg0_in, neg1_in;
  logic [WIDTH-1:0]   mag0_in, mag1_in;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge, last_step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign op_in     = mdu_op_e'(bus.op);
  assign in_signed = op_is_signed(op_in);
  assign neg0_in   = in_signed & bus.in0[WIDTH-1];
  assign neg1_in   = in_signed & bus.in1[WIDTH-1];

  mdu_sign_fix #(.W(WIDTH)) u_mag0 (.neg(neg0_in), .a(bus.in0), .y(mag0_in));
  mdu_sign_fix #(.W(WIDTH)) u_mag1 (.neg(neg1_in), .a(bus.in1), .y(mag1_in));

  // Multiply: acc:q is the running product, multiplier consumed from q[0].
  assign mul_sum   = {1'b0, acc} + {1'b0, (b & {WIDTH{q[0]}})};
  // Divide: acc is the partial remainder, dividend bits shift out of q's top.
  assign div_shift = {acc, q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, b};
  assign div_diff  = div_shift[WIDTH-1:0] - b;

  assign last_step = (cnt == CW'(WIDTH));

  mdu_sign_fix #(.W(2*WIDTH)) u_prod (.neg(sign0 ^ sign1), .a({acc, q}), .y(prod_fix));
  mdu_sign_fix #(.W(WIDTH))   u_quo  (.neg(sign0 ^ sign1), .a(q),        .y(quo_fix));
  mdu_sign_fix #(.W(WIDTH))   u_rem  (.neg(sign0),         .a(acc),      .y(rem_fix));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= MDU_MULT;
      sign0  <= 1'b0;
      sign1  <= 1'b0;
      dz     <= 1'b0;
      cnt    <= '0;
      b      <= '0;
      acc    <= '0;
      q      <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q  <= op_in;
            sign0 <= neg0_in;
            sign1 <= neg1_in;
            dz    <= op_is_div(op_in) && (bus.in1 == '0);
            cnt   <= '0;
            acc   <= '0;
            if (op_is_div(op_in)) begin
              b <= mag1_in;
              q <= mag0_in;
            end else begin
              b <= mag0_in;
              q <= mag1_in;
            end
          end
        end
        RUN: begin
          if (!last_step) begin
            cnt <= cnt + 1'b1;
            if (op_is_div(op_q)) begin
              if (div_ge) begin
                acc <= div_diff;
                q   <= {q[WIDTH-2:0], 1'b1};
              end else begin
                acc <= div_shift[WIDTH-1:0];
                q   <= {q[WIDTH-2:0], 1'b0};
              end
            end else begin
              acc <= mul_sum[WIDTH:1];
              q   <= {mul_sum[0], q[WIDTH-1:1]};
            end
          end
        end
        FIN: begin
          done_q <= 1'b1;
          if (op_is_div(op_q)) begin
            // With a zero divisor every step "subtracts" 0, so acc ends holding
            // the dividend magnitude and rem_fix restores the original in0.
            hi_q  <= rem_fix;
            lo_q  <= dz ? '1 : quo_fix;
            dbz_q <= dz;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Iterative multiply/divide unit for the pipelined MIPS datapath. Sits in EX beside the single-cycle ALU.
- Takes the long-latency ops (mult, multu, div, divu) through a start/busy/done handshake.
- Holds the architectural HI/LO registers that mfhi/mflo read.
- The hazard unit stalls on busy.

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
op  input  2  00 mult, 01 multu, 10 div, 11 divu.
in0  input  WIDTH  multiplicand / dividend (rs).
in1  input  WIDTH  multiplier / divisor (rt).
busy  output  1  high whenever state is not IDLE.
done  output  1  one-cycle pulse when hi/lo have been updated.
div_by_zero  output  1  pulses with done when a div/divu had in1 == 0.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high, on ports clk and reset.
- Reset values: state IDLE, busy 0, done 0, div_by_zero 0, hi 0, lo 0, iteration counter 0, internal work registers 0.
- Reset mid-operation: abort immediately. No done pulse is produced and hi/lo read 0.
- States:
  - IDLE: on start, latch op, latch |in0| and |in1| (magnitudes for signed ops, raw values for unsigned), and latch the sign flags. Clear the counter. Go to RUN.
  - RUN: one shift-add (mult) or restoring shift-subtract (div) step per cycle. Counter increments each cycle. After WIDTH steps go to FIN.
  - FIN: apply sign correction, then go to IDLE. On that edge write hi/lo, set done = 1, and set div_by_zero as applicable.
- Latency:
  - start sampled at edge t; busy = 1 after edges t .. t+WIDTH+1.
  - done = 1 and hi/lo valid after edge t+WIDTH+2, i.e. 34 cycles for WIDTH = 32.
- Handshake:
  - start while busy is ignored; no queuing.
  - start in the same cycle that done = 1 is accepted, since state is IDLE.
  - done and div_by_zero drop after one cycle.
  - hi/lo hold their values until the next FIN→IDLE transition or reset.
- Multiply: {hi, lo} = full 2·WIDTH-bit product.
  - Signed: negate the magnitude product when sign0 XOR sign1.
  - 0x80000000 is handled as an unsigned magnitude 2^31.
- Divide: lo = quotient, hi = remainder.
  - Signed: quotient negated when sign0 XOR sign1; remainder takes the sign of in0 (truncating division).
  - Overflow: 0x80000000 / 0xFFFFFFFF (signed) gives lo = 0x80000000, hi = 0 (wraps, no flag).
- Divide by zero (in1 == 0, div or divu):
  - Full latency is still taken.
  - hi = in0 as latched, lo = all ones, div_by_zero = 1 together with done.
- Operands are latched in IDLE. in0/in1/op may change freely while busy without effect.

Decomposition:
- Shared package mdu_pkg:
  - op encodings MDU_MULT / MDU_MULTU / MDU_DIV / MDU_DIVU.
  - state encoding IDLE / RUN / FIN.
  - WIDTH default.
- One sub-module mdu_sign_fix: combinational conditional two's-complement negate of a value, parameterised by width. Instantiated for operand magnitude and for result correction.
- Datapath and FSM stay in mdu.

Test Plan:
- mult 7 × 0xFFFFFFFD (−3), start at edge t → busy 1 for 34 cycles; done at edge t+34; hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
- multu 0xFFFFFFFF × 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001. Then mult on the same operands → hi = 0, lo = 1.
- div 0xFFFFFFF9 (−7) / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. divu 100 / 7 → lo = 14, hi = 2.
- divu 100 / 0 → done and div_by_zero both 1 for one cycle; hi = 100, lo = 0xFFFFFFFF. div 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0, div_by_zero = 0.
- Start pulse with new operands at cycle 10 of a busy op → ignored; result matches the first op. start asserted in the done cycle → accepted, busy is 1 on the next cycle.
- Assert reset asynchronously mid-RUN → busy, done, hi, lo go to 0 without waiting for a clock edge. No done pulse follows; the next start runs normally.
